// File: rtl/cdb_writeback_pkg.sv
// Shared widths, RS tag encoding and result record for the CDB writeback slice.
// Tags 1..6 name the six RS entries; 0 means "no producer" and 7 is never legal.
package cdb_writeback_pkg;

  localparam int NUM_UNITS = 4;
  localparam int DATA_W    = 16;
  localparam int NUM_REGS  = 16;
  localparam int REG_W     = 4;
  localparam int TAG_W     = 3;
  localparam int PTR_W     = 2;
  localparam int NUM_RS    = 6;
  localparam int CNT_W     = 16;

  localparam logic [TAG_W-1:0] TAG_NONE    = 3'd0;
  localparam logic [TAG_W-1:0] TAG_ADD0    = 3'd1;
  localparam logic [TAG_W-1:0] TAG_ADD1    = 3'd2;
  localparam logic [TAG_W-1:0] TAG_ADD2    = 3'd3;
  localparam logic [TAG_W-1:0] TAG_MUL0    = 3'd4;
  localparam logic [TAG_W-1:0] TAG_MUL1    = 3'd5;
  localparam logic [TAG_W-1:0] TAG_MUL2    = 3'd6;
  localparam logic [TAG_W-1:0] TAG_ILLEGAL = 3'd7;

  localparam logic [PTR_W-1:0] UNIT_ADD0 = 2'd0;
  localparam logic [PTR_W-1:0] UNIT_ADD1 = 2'd1;
  localparam logic [PTR_W-1:0] UNIT_MUL0 = 2'd2;
  localparam logic [PTR_W-1:0] UNIT_MUL1 = 2'd3;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic [REG_W-1:0]  rdest;
  } result_t;

  function automatic logic tag_legal(input logic [TAG_W-1:0] t);
    return (t != TAG_NONE) && (t != TAG_ILLEGAL);
  endfunction

  function automatic logic [NUM_RS-1:0] tag_onehot(input logic [TAG_W-1:0] t);
    logic [NUM_RS-1:0] oh;
    oh = '0;
    if (tag_legal(t)) oh = NUM_RS'(1) << (t - TAG_ADD0);
    return oh;
  endfunction

endpackage

// File: rtl/cdb_writeback_rr_arbiter4.sv
// Four-way round-robin arbiter, purely combinational: the search starts one past ptr,
// so the unit granted last time has the lowest priority this time.
module rr_arbiter4
  import cdb_writeback_pkg::*;
(
  input  logic [NUM_UNITS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_UNITS-1:0] gnt,
  output logic [PTR_W-1:0]     gnt_idx,
  output logic                 gnt_vld
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int off = 1; off <= NUM_UNITS; off++) begin
      idx = ptr + PTR_W'(off);
      if (!gnt_vld && req[idx]) begin
        gnt_vld      = 1'b1;
        gnt_idx      = idx;
        gnt[idx]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_writeback.sv
// Collects execution-unit results into per-unit slots and serialises them onto the CDB,
// one registered broadcast per cycle; owns the register result-status table.
module cdb_writeback
  import cdb_writeback_pkg::*;
(
  input  logic                          clock1,
  input  logic                          reset_n,
  input  logic [NUM_UNITS-1:0]          ex_valid,
  output logic [NUM_UNITS-1:0]          ex_ready,
  input  logic [NUM_UNITS*DATA_W-1:0]   ex_data,
  input  logic [NUM_UNITS*TAG_W-1:0]    ex_tag,
  input  logic [NUM_UNITS*REG_W-1:0]    ex_rdest,
  input  logic                          iss_valid,
  input  logic [REG_W-1:0]              iss_rdest,
  input  logic [TAG_W-1:0]              iss_tag,
  input  logic [REG_W-1:0]              q_addr1,
  input  logic [REG_W-1:0]              q_addr2,
  output logic [TAG_W-1:0]              q_tag1,
  output logic [TAG_W-1:0]              q_tag2,
  output logic                          cdb_valid,
  output logic [TAG_W-1:0]              cdb_tag,
  output logic [DATA_W-1:0]             cdb_data,
  output logic                          rf_we,
  output logic [REG_W-1:0]              rf_addr,
  output logic [DATA_W-1:0]             rf_data,
  output logic [NUM_RS-1:0]             rs_free,
  output logic [CNT_W-1:0]              bcast_count,
  output logic                          err_tag
);

  logic [NUM_UNITS-1:0] slot_vld_q, slot_vld_d;
  result_t              slot_q [NUM_UNITS];
  result_t              slot_d [NUM_UNITS];
  logic [TAG_W-1:0]     status_q [NUM_REGS];
  logic [TAG_W-1:0]     status_d [NUM_REGS];
  logic [PTR_W-1:0]     ptr_q, ptr_d;

  logic                 cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]     cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]    cdb_data_q, cdb_data_d;
  logic                 rf_we_q, rf_we_d;
  logic [REG_W-1:0]     rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]    rf_data_q, rf_data_d;
  logic [NUM_RS-1:0]    rs_free_q, rs_free_d;
  logic [CNT_W-1:0]     bcast_count_q, bcast_count_d;
  logic                 err_tag_q, err_tag_d;

  result_t              ex_res [NUM_UNITS];
  logic [NUM_UNITS-1:0] ex_illegal;
  logic [NUM_UNITS-1:0] ex_acc;
  logic [NUM_UNITS-1:0] slot_legal;
  logic [NUM_UNITS-1:0] slot_drop;
  logic [NUM_UNITS-1:0] gnt;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  result_t              win;
  logic                 hit;

  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      ex_res[i].data  = ex_data[i*DATA_W +: DATA_W];
      ex_res[i].tag   = ex_tag[i*TAG_W +: TAG_W];
      ex_res[i].rdest = ex_rdest[i*REG_W +: REG_W];
      ex_illegal[i]   = !tag_legal(ex_res[i].tag);
      slot_legal[i]   = slot_vld_q[i] && tag_legal(slot_q[i].tag);
      slot_drop[i]    = slot_vld_q[i] && !tag_legal(slot_q[i].tag);
    end
  end

  rr_arbiter4 u_arb (
    .req     (slot_legal),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // A granted slot drains this edge, so it may be refilled in the same cycle.
  assign ex_ready = ~slot_vld_q | gnt;
  assign ex_acc   = ex_valid & ex_ready;
  assign win      = slot_q[gnt_idx];
  assign hit      = gnt_vld && (status_q[win.rdest] == win.tag);

  always_comb begin
    slot_vld_d = slot_vld_q;
    for (int i = 0; i < NUM_UNITS; i++) begin
      slot_d[i] = slot_q[i];
      if (gnt[i] || slot_drop[i]) slot_vld_d[i] = 1'b0;
      if (ex_acc[i]) begin
        slot_vld_d[i] = 1'b1;
        slot_d[i]     = ex_res[i];
      end
    end
    err_tag_d = err_tag_q | (|(ex_acc & ex_illegal));
    ptr_d     = gnt_vld ? gnt_idx : ptr_q;
  end

  // Rename is applied after the clear so a newer producer always survives.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) status_d[r] = status_q[r];
    if (hit) status_d[win.rdest] = TAG_NONE;
    if (iss_valid) status_d[iss_rdest] = iss_tag;
  end

  always_comb begin
    cdb_valid_d   = gnt_vld;
    cdb_tag_d     = gnt_vld ? win.tag : cdb_tag_q;
    cdb_data_d    = gnt_vld ? win.data : cdb_data_q;
    rs_free_d     = gnt_vld ? tag_onehot(win.tag) : '0;
    bcast_count_d = bcast_count_q + CNT_W'(gnt_vld);
    rf_we_d       = hit;
    rf_addr_d     = hit ? win.rdest : rf_addr_q;
    rf_data_d     = hit ? win.data : rf_data_q;
  end

  always_ff @(posedge clock1 or negedge reset_n) begin
    if (!reset_n) begin
      slot_vld_q    <= '0;
      slot_q        <= '{default: '0};
      status_q      <= '{default: '0};
      ptr_q         <= UNIT_MUL1;
      cdb_valid_q   <= 1'b0;
      cdb_tag_q     <= '0;
      cdb_data_q    <= '0;
      rf_we_q       <= 1'b0;
      rf_addr_q     <= '0;
      rf_data_q     <= '0;
      rs_free_q     <= '0;
      bcast_count_q <= '0;
      err_tag_q     <= 1'b0;
    end else begin
      slot_vld_q    <= slot_vld_d;
      slot_q        <= slot_d;
      status_q      <= status_d;
      ptr_q         <= ptr_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_tag_q     <= cdb_tag_d;
      cdb_data_q    <= cdb_data_d;
      rf_we_q       <= rf_we_d;
      rf_addr_q     <= rf_addr_d;
      rf_data_q     <= rf_data_d;
      rs_free_q     <= rs_free_d;
      bcast_count_q <= bcast_count_d;
      err_tag_q     <= err_tag_d;
    end
  end

  assign q_tag1      = status_q[q_addr1];
  assign q_tag2      = status_q[q_addr2];
  assign cdb_valid   = cdb_valid_q;
  assign cdb_tag     = cdb_tag_q;
  assign cdb_data    = cdb_data_q;
  assign rf_we       = rf_we_q;
  assign rf_addr     = rf_addr_q;
  assign rf_data     = rf_data_q;
  assign rs_free     = rs_free_q;
  assign bcast_count = bcast_count_q;
  assign err_tag     = err_tag_q;

endmodule

// File: tb/tb_cdb_writeback.sv
// Directed and random stimulus for cdb_writeback, checked each cycle against a
// transaction-level model of the slots, the status table and the round-robin order.
module tb_cdb_writeback;
  import cdb_writeback_pkg::*;

  logic                        clock1 = 1'b0;
  logic                        reset_n = 1'b0;
  logic [NUM_UNITS-1:0]        ex_valid;
  logic [NUM_UNITS-1:0]        ex_ready;
  logic [NUM_UNITS*DATA_W-1:0] ex_data;
  logic [NUM_UNITS*TAG_W-1:0]  ex_tag;
  logic [NUM_UNITS*REG_W-1:0]  ex_rdest;
  logic                        iss_valid;
  logic [REG_W-1:0]            iss_rdest;
  logic [TAG_W-1:0]            iss_tag;
  logic [REG_W-1:0]            q_addr1, q_addr2;
  logic [TAG_W-1:0]            q_tag1, q_tag2;
  logic                        cdb_valid;
  logic [TAG_W-1:0]            cdb_tag;
  logic [DATA_W-1:0]           cdb_data;
  logic                        rf_we;
  logic [REG_W-1:0]            rf_addr;
  logic [DATA_W-1:0]           rf_data;
  logic [NUM_RS-1:0]           rs_free;
  logic [CNT_W-1:0]            bcast_count;
  logic                        err_tag;

  cdb_writeback dut (
    .clock1(clock1), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_data(ex_data), .ex_tag(ex_tag), .ex_rdest(ex_rdest),
    .iss_valid(iss_valid), .iss_rdest(iss_rdest), .iss_tag(iss_tag),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_tag1(q_tag1), .q_tag2(q_tag2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .rs_free(rs_free), .bcast_count(bcast_count), .err_tag(err_tag)
  );

  always #5 clock1 = ~clock1;

  int n_vec = 0;
  int n_err = 0;

  // Model: pending results per unit, register owners, last-served unit.
  bit m_v [4];
  int m_d [4];
  int m_t [4];
  int m_r [4];
  int m_status [16];
  int m_last;
  int m_count;
  bit m_err;
  bit e_cdb_v, e_we;
  int e_cdb_t, e_cdb_d, e_waddr, e_wdata, e_free;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic bit legal(input int t);
    return (t >= 1) && (t <= 6);
  endfunction

  task automatic m_reset();
    for (int u = 0; u < 4; u++) begin
      m_v[u] = 0; m_d[u] = 0; m_t[u] = 0; m_r[u] = 0;
    end
    for (int r = 0; r < 16; r++) m_status[r] = 0;
    m_last = 3; m_count = 0; m_err = 0;
    e_cdb_v = 0; e_we = 0; e_free = 0;
  endtask

  task automatic do_reset();
    ex_valid = '0; iss_valid = 1'b0;
    reset_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clock1);
    #3 reset_n = 1'b1;
  endtask

  task automatic send(input int u, input int data, input int tag, input int rd);
    ex_valid[u] = 1'b1;
    ex_data[u*DATA_W +: DATA_W] = data[15:0];
    ex_tag[u*TAG_W +: TAG_W]    = tag[2:0];
    ex_rdest[u*REG_W +: REG_W]  = rd[3:0];
  endtask

  task automatic ren(input int rd, input int tag);
    iss_valid = 1'b1;
    iss_rdest = rd[3:0];
    iss_tag   = tag[2:0];
  endtask

  // One clock: check combinational outputs, predict the edge, then check registered outputs.
  task automatic step();
    int g, u;
    bit [3:0] e_rdy;
    #1;
    g = -1;
    for (int k = 1; k <= 4; k++) begin
      u = (m_last + k) % 4;
      if (g < 0 && m_v[u] && legal(m_t[u])) g = u;
    end
    for (int i = 0; i < 4; i++) e_rdy[i] = !m_v[i] || (g == i);
    chk("ex_ready", ex_ready, e_rdy);
    chk("q_tag1", q_tag1, m_status[q_addr1]);
    chk("q_tag2", q_tag2, m_status[q_addr2]);

    e_cdb_v = (g >= 0); e_we = 0; e_free = 0;
    if (g >= 0) begin
      e_cdb_t = m_t[g]; e_cdb_d = m_d[g];
      e_free  = 1 << (m_t[g] - 1);
      m_count = (m_count + 1) % 65536;
      if (m_status[m_r[g]] == m_t[g]) begin
        e_we = 1; e_waddr = m_r[g]; e_wdata = m_d[g];
        m_status[m_r[g]] = 0;
      end
      m_v[g] = 0;
      m_last = g;
    end
    if (iss_valid) m_status[iss_rdest] = iss_tag;
    for (int i = 0; i < 4; i++) if (m_v[i] && !legal(m_t[i])) m_v[i] = 0;
    for (int i = 0; i < 4; i++) begin
      if (ex_valid[i] && e_rdy[i]) begin
        m_v[i] = 1;
        m_d[i] = ex_data[i*DATA_W +: DATA_W];
        m_t[i] = ex_tag[i*TAG_W +: TAG_W];
        m_r[i] = ex_rdest[i*REG_W +: REG_W];
        if (!legal(m_t[i])) m_err = 1;
      end
    end

    @(posedge clock1);
    #1;
    chk("cdb_valid", cdb_valid, e_cdb_v);
    if (e_cdb_v) begin
      chk("cdb_tag", cdb_tag, e_cdb_t);
      chk("cdb_data", cdb_data, e_cdb_d);
    end
    chk("rf_we", rf_we, e_we);
    if (e_we) begin
      chk("rf_addr", rf_addr, e_waddr);
      chk("rf_data", rf_data, e_wdata);
    end
    chk("rs_free", rs_free, e_free);
    chk("bcast_count", bcast_count, m_count);
    chk("err_tag", err_tag, m_err);
    ex_valid = '0;
    iss_valid = 1'b0;
  endtask

  initial begin
    int rr_tags [4];
    rr_tags = '{1, 2, 4, 5};
    ex_valid = '0; ex_data = '0; ex_tag = '0; ex_rdest = '0;
    iss_valid = 1'b0; iss_rdest = '0; iss_tag = '0;
    q_addr1 = '0; q_addr2 = '0;

    do_reset();
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_cdb_tag", cdb_tag, 0);
    chk("rst_cdb_data", cdb_data, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_rf_data", rf_data, 0);
    chk("rst_rs_free", rs_free, 0);
    chk("rst_bcast", bcast_count, 0);
    chk("rst_err", err_tag, 0);
    chk("rst_ready", ex_ready, 4'b1111);

    // Single result written back to R5
    ren(5, 1); step();
    send(0, 'h0042, 1, 5); step();
    q_addr1 = 4'd5; step();
    chk("single_cdb_tag", cdb_tag, 1);
    chk("single_cdb_data", cdb_data, 'h0042);
    chk("single_rf_we", rf_we, 1);
    chk("single_rf_addr", rf_addr, 5);
    chk("single_rf_data", rf_data, 'h0042);
    chk("single_rs_free", rs_free, 6'b000001);
    chk("single_bcast", bcast_count, 1);
    #1 chk("single_qtag", q_tag1, 0);

    // All four units at once after reset: served 0,1,2,3
    do_reset();
    for (int u = 0; u < 4; u++) send(u, 'h1000 + u, rr_tags[u], u + 1);
    step();
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_ready_granted", ex_ready[k], 1);
      step();
      chk("rr_order_tag", cdb_tag, rr_tags[k]);
    end

    // Stale result: R3 renamed past tag 4
    ren(3, 4); step();
    ren(3, 5); step();
    send(2, 'h1234, 4, 3); step();
    q_addr1 = 4'd3; step();
    chk("stale_cdb_valid", cdb_valid, 1);
    chk("stale_cdb_tag", cdb_tag, 4);
    chk("stale_rs_free", rs_free, 6'b001000);
    chk("stale_rf_we", rf_we, 0);
    #1 chk("stale_qtag", q_tag1, 5);

    // Rename R7 in the same cycle its old producer broadcasts
    ren(7, 1); step();
    send(0, 'hbeef, 1, 7); step();
    ren(7, 2); step();
    chk("simul_rf_we", rf_we, 1);
    chk("simul_rf_addr", rf_addr, 7);
    chk("simul_rf_data", rf_data, 'hbeef);
    q_addr1 = 4'd7;
    #1 chk("simul_qtag", q_tag1, 2);

    // Illegal tag is dropped and flagged sticky
    send(1, 'h7777, 7, 9); step();
    chk("illegal_err", err_tag, 1);
    step();
    chk("illegal_no_cdb", cdb_valid, 0);
    #1 chk("illegal_slot_freed", ex_ready[1], 1);
    send(1, 'h5555, 3, 9); step(); step();
    chk("after_illegal_cdb", cdb_valid, 1);
    chk("after_illegal_tag", cdb_tag, 3);
    chk("after_illegal_err", err_tag, 1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int u = 0; u < 4; u++) begin
        if ($urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 15) == 0) send(u, $urandom, ($urandom_range(0, 1) == 1) ? 7 : 0, $urandom_range(0, 15));
          else send(u, $urandom, $urandom_range(1, 6), $urandom_range(0, 15));
        end
      end
      if ($urandom_range(0, 2) == 0) ren($urandom_range(0, 15), $urandom_range(1, 6));
      q_addr1 = 4'($urandom_range(0, 15));
      q_addr2 = 4'($urandom_range(0, 15));
      step();
    end

    // Reset while three slots hold results
    do_reset();
    send(0, 'h0a0a, 1, 1); send(1, 'h0b0b, 2, 2); send(2, 'h0c0c, 4, 3);
    step();
    #2 reset_n = 1'b0;
    m_reset();
    #1;
    chk("midrst_ready", ex_ready, 4'b1111);
    chk("midrst_cdb_valid", cdb_valid, 0);
    @(posedge clock1);
    #3 reset_n = 1'b1;
    repeat (3) step();
    chk("midrst_bcast", bcast_count, 0);
    send(0, 'h00d0, 4, 1); send(1, 'h00d1, 5, 2); send(2, 'h00d2, 6, 3); send(3, 'h00d3, 1, 4);
    step(); step();
    chk("midrst_first_unit0", cdb_tag, 4);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
